grid_arbiter: RTL and testbench

- Shares the single-port 40x30 level-grid RAM (3-bit cells) between three requesters: level loader (write stream), game logic (read/write) and renderer/raycaster (read).
- Computes the linear RAM address, enforces priority with a renderer anti-starvation counter, and grants the loader an exclusive lock for a whole level load.
- Sits between the requesters and the grid RAM instance.

---
 rtl/grid_arbiter_pkg.sv | 32 +++
 rtl/grid_addr_calc.sv | 14 +
 rtl/grid_arbiter.sv | 157 +++++++++++++++
 tb/tb_grid_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_arbiter_pkg.sv
// Shared level-grid definitions used by the loader, the renderer and the grid arbiter.
// Cell codes, grid geometry and the arbiter's lock states live here.
package grid_arbiter_pkg;

    localparam int GRID_W       = 40;
    localparam int GRID_H       = 30;
    localparam int CELL_W       = 3;
    localparam int ADDR_W       = 11;
    localparam int X_W          = 6;
    localparam int Y_W          = 5;
    localparam int MAX_WAIT_DEF = 8;

    typedef enum logic [CELL_W-1:0] {
        CELL_EMPTY = 3'd0,
        CELL_WALL  = 3'd1,
        CELL_DOOR  = 3'd2,
        CELL_EXIT  = 3'd3
    } cell_e;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_GAME   = 2'd1,
        SRC_RENDER = 2'd2,
        SRC_LOADER = 2'd3
    } src_e;

endpackage

// File: rtl/grid_addr_calc.sv
// Combinational cell coordinate to linear RAM address, plus a bounds flag.
module grid_addr_calc
    import grid_arbiter_pkg::*;
(
    input  logic [X_W-1:0]    x_i,
    input  logic [Y_W-1:0]    y_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              in_range_o
);

    assign addr_o     = ADDR_W'(y_i) * ADDR_W'(GRID_W) + ADDR_W'(x_i);
    assign in_range_o = (x_i < X_W'(GRID_W)) && (y_i < Y_W'(GRID_H));

endmodule

// File: rtl/grid_arbiter.sv
// Shares the single-port level-grid RAM between loader, game logic and renderer.
// Game beats renderer unless the renderer has waited MAX_WAIT cycles; the loader locks the grid.
module grid_arbiter
    import grid_arbiter_pkg::*;
#(
    parameter int                MAX_WAIT  = MAX_WAIT_DEF,
    parameter logic [CELL_W-1:0] OOB_VALUE = CELL_WALL
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_lock,
    input  logic [X_W-1:0]    ld_x,
    input  logic [Y_W-1:0]    ld_y,
    input  logic [CELL_W-1:0] ld_data,
    input  logic              ld_write,
    input  logic              gm_req,
    input  logic              gm_we,
    input  logic [X_W-1:0]    gm_x,
    input  logic [Y_W-1:0]    gm_y,
    input  logic [CELL_W-1:0] gm_wdata,
    output logic              gm_gnt,
    output logic              gm_rvalid,
    input  logic              rn_req,
    input  logic [X_W-1:0]    rn_x,
    input  logic [Y_W-1:0]    rn_y,
    output logic              rn_gnt,
    output logic              rn_rvalid,
    output logic [CELL_W-1:0] rd_data,
    output logic              ld_active,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CELL_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [CELL_W-1:0] mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              gm_rvalid_q, rn_rvalid_q, oob_q;
    src_e              src;
    logic              rn_win;
    logic [X_W-1:0]    sel_x;
    logic [Y_W-1:0]    sel_y;
    logic [ADDR_W-1:0] calc_addr;
    logic              in_range;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:    if (ld_lock)  state_d = ST_LOCKED;
            ST_LOCKED: if (!ld_lock) state_d = ST_ARB;
            default:   state_d = ST_ARB;
        endcase
    end

    assign rn_win = rn_req && (wait_q >= WAIT_W'(MAX_WAIT));

    // The cycle ld_lock rises is spent quiet so the loader starts on an idle port.
    always_comb begin
        src       = SRC_NONE;
        gm_gnt    = 1'b0;
        rn_gnt    = 1'b0;
        ld_active = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_ARB: begin
                    if (!ld_lock) begin
                        if (rn_req && (rn_win || !gm_req)) begin
                            rn_gnt = 1'b1;
                            src    = SRC_RENDER;
                        end else if (gm_req) begin
                            gm_gnt = 1'b1;
                            src    = SRC_GAME;
                        end
                    end
                end
                ST_LOCKED: begin
                    ld_active = 1'b1;
                    src       = SRC_LOADER;
                end
                default: src = SRC_NONE;
            endcase
        end
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        case (src)
            SRC_GAME:   begin sel_x = gm_x; sel_y = gm_y; end
            SRC_RENDER: begin sel_x = rn_x; sel_y = rn_y; end
            SRC_LOADER: begin sel_x = ld_x; sel_y = ld_y; end
            default:    begin sel_x = '0;   sel_y = '0;   end
        endcase
    end

    grid_addr_calc u_addr_calc (
        .x_i        (sel_x),
        .y_i        (sel_y),
        .addr_o     (calc_addr),
        .in_range_o (in_range)
    );

    // Out-of-range writes still consume their grant; only the RAM strobe is suppressed.
    always_comb begin
        mem_addr  = (src == SRC_NONE) ? '0 : calc_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (src == SRC_LOADER) begin
            mem_wdata = ld_data;
            mem_we    = ld_write && in_range;
        end else if (src == SRC_GAME && gm_we) begin
            mem_wdata = gm_wdata;
            mem_we    = in_range;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (state_q == ST_ARB) begin
            if (rn_gnt) begin
                wait_d = '0;
            end else if (rn_req && (wait_q < WAIT_W'(MAX_WAIT))) begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_q      <= '0;
            gm_rvalid_q <= 1'b0;
            rn_rvalid_q <= 1'b0;
            oob_q       <= 1'b0;
        end else begin
            wait_q      <= wait_d;
            gm_rvalid_q <= gm_gnt && !gm_we;
            rn_rvalid_q <= rn_gnt;
            oob_q       <= !in_range;
        end
    end

    // Gating with reset keeps a read granted just before reset from surfacing.
    assign gm_rvalid = gm_rvalid_q && !reset;
    assign rn_rvalid = rn_rvalid_q && !reset;
    assign rd_data   = (gm_rvalid || rn_rvalid) ? (oob_q ? OOB_VALUE : mem_rdata) : '0;

endmodule

// File: tb/tb_grid_arbiter.sv
// Directed bench for grid_arbiter with a small behavioural grid RAM.
// Expected port activity is queued per cycle; a negedge monitor compares every active cycle.
module tb_grid_arbiter;

    localparam int W = 23;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ld_lock = 1'b0;
    logic [5:0]  ld_x = '0;
    logic [4:0]  ld_y = '0;
    logic [2:0]  ld_data = '0;
    logic        ld_write = 1'b0;
    logic        gm_req = 1'b0;
    logic        gm_we = 1'b0;
    logic [5:0]  gm_x = '0;
    logic [4:0]  gm_y = '0;
    logic [2:0]  gm_wdata = '0;
    logic        gm_gnt, gm_rvalid;
    logic        rn_req = 1'b0;
    logic [5:0]  rn_x = '0;
    logic [4:0]  rn_y = '0;
    logic        rn_gnt, rn_rvalid;
    logic [2:0]  rd_data;
    logic        ld_active;
    logic [10:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic        mem_we;
    logic [2:0]  mem_rdata = '0;

    logic [2:0]   ram [0:2047];
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    grid_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .ld_lock   (ld_lock),
        .ld_x      (ld_x),
        .ld_y      (ld_y),
        .ld_data   (ld_data),
        .ld_write  (ld_write),
        .gm_req    (gm_req),
        .gm_we     (gm_we),
        .gm_x      (gm_x),
        .gm_y      (gm_y),
        .gm_wdata  (gm_wdata),
        .gm_gnt    (gm_gnt),
        .gm_rvalid (gm_rvalid),
        .rn_req    (rn_req),
        .rn_x      (rn_x),
        .rn_y      (rn_y),
        .rn_gnt    (rn_gnt),
        .rn_rvalid (rn_rvalid),
        .rd_data   (rd_data),
        .ld_active (ld_active),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    // Clock / reset and RAM model
    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = '0;
    end

    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Expected vector layout: gm_gnt rn_gnt gm_rvalid rn_rvalid mem_we ld_active addr wdata rd_data
    function automatic logic [W-1:0] ev(bit gg, bit rg, bit gv, bit rv, bit we, bit la,
                                        int addr, int wd, int rd);
        return {gg, rg, gv, rv, we, la, 11'(addr), 3'(wd), 3'(rd)};
    endfunction

    task automatic expect_ev(input string nm, input logic [W-1:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_gm_gnt"}, int'(gm_gnt), 0);
        chk({nm, "_rn_gnt"}, int'(rn_gnt), 0);
        chk({nm, "_gm_rvalid"}, int'(gm_rvalid), 0);
        chk({nm, "_rn_rvalid"}, int'(rn_rvalid), 0);
        chk({nm, "_mem_we"}, int'(mem_we), 0);
        chk({nm, "_ld_active"}, int'(ld_active), 0);
        chk({nm, "_mem_addr"}, int'(mem_addr), 0);
        chk({nm, "_mem_wdata"}, int'(mem_wdata), 0);
        chk({nm, "_rd_data"}, int'(rd_data), 0);
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        logic [W-1:0] act;
        logic [W-1:0] exp_v;
        string        nm;
        act = {gm_gnt, rn_gnt, gm_rvalid, rn_rvalid, mem_we, ld_active, mem_addr, mem_wdata, rd_data};
        if (gm_gnt || rn_gnt || gm_rvalid || rn_rvalid || mem_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event actual=%h expected=none", act);
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (act !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
                end
            end
        end
    end

    // Game write (0,1)=2 against renderer read (rx,0); renderer wins on the 9th cycle.
    task automatic contention(input int rx, input int rd);
        gm_req = 1; gm_we = 1; gm_x = 6'd0; gm_y = 5'd1; gm_wdata = 3'd2;
        rn_req = 1; rn_x = 6'(rx); rn_y = 5'd0;
        for (int i = 0; i < 8; i++) begin
            expect_ev("cont_gm", ev(1, 0, 0, 0, 1, 0, 40, 2, 0));
            tick();
        end
        expect_ev("cont_rn_win", ev(0, 1, 0, 0, 0, 0, rx, 0, 0));
        tick();
        rn_req = 0;
        expect_ev("cont_gm_resume", ev(1, 0, 0, 1, 1, 0, 40, 2, rd));
        tick();
        gm_req = 0; gm_we = 0;
        tick();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk_all_zero("rst");
        tick();
        reset = 0;
        @(negedge clock);
        chk_all_zero("idle");
        tick();

        // Game writes
        gm_req = 1; gm_we = 1; gm_x = 6'd5; gm_y = 5'd2; gm_wdata = 3'd3;
        expect_ev("gm_wr_85", ev(1, 0, 0, 0, 1, 0, 85, 3, 0));
        tick();
        gm_x = 6'd39; gm_y = 5'd29; gm_wdata = 3'd6;
        expect_ev("gm_wr_1199", ev(1, 0, 0, 0, 1, 0, 1199, 6, 0));
        tick();
        gm_x = 6'd3; gm_y = 5'd0; gm_wdata = 3'd5;
        expect_ev("gm_wr_3", ev(1, 0, 0, 0, 1, 0, 3, 5, 0));
        tick();
        gm_req = 0; gm_we = 0;
        tick();

        // Renderer read at the far corner
        rn_req = 1; rn_x = 6'd39; rn_y = 5'd29;
        expect_ev("rn_rd_1199", ev(0, 1, 0, 0, 0, 0, 1199, 0, 0));
        tick();
        rn_req = 0;
        expect_ev("rn_rvalid_1199", ev(0, 0, 0, 1, 0, 0, 0, 0, 6));
        tick();

        contention(3, 5);

        // Out-of-range accesses
        gm_req = 1; gm_we = 0; gm_x = 6'd40; gm_y = 5'd0;
        expect_ev("gm_rd_oob", ev(1, 0, 0, 0, 0, 0, 40, 0, 0));
        tick();
        gm_we = 1; gm_x = 6'd0; gm_y = 5'd30; gm_wdata = 3'd7;
        expect_ev("gm_wr_oob_and_oob_rvalid", ev(1, 0, 1, 0, 0, 0, 1200, 7, 1));
        tick();
        gm_req = 0; gm_we = 0;
        tick();

        // Read granted just before the lock, then the lock request cycle
        gm_req = 1; gm_we = 0; gm_x = 6'd3; gm_y = 5'd0;
        expect_ev("gm_rd_prelock", ev(1, 0, 0, 0, 0, 0, 3, 0, 0));
        tick();
        gm_x = 6'd1; gm_y = 5'd1;
        ld_lock = 1; ld_write = 1; ld_x = 6'd0; ld_y = 5'd0; ld_data = 3'd7;
        expect_ev("gm_rvalid_lock_edge", ev(0, 0, 1, 0, 0, 0, 0, 0, 5));
        tick();

        // Full level load with game request still pending
        for (int y = 0; y < 30; y++) begin
            for (int x = 0; x < 40; x++) begin
                ld_x = 6'(x); ld_y = 5'(y); ld_data = 3'((x + y) & 7); ld_write = 1;
                expect_ev("ld_write", ev(0, 0, 0, 0, 1, 1, y * 40 + x, (x + y) & 7, 0));
                tick();
            end
        end
        ld_write = 0;
        @(negedge clock);
        chk("ld_active_held", int'(ld_active), 1);
        tick();
        ld_lock = 0;
        @(negedge clock);
        chk("ld_active_release_cycle", int'(ld_active), 1);
        tick();
        expect_ev("gm_rd_after_lock", ev(1, 0, 0, 0, 0, 0, 41, 0, 0));
        @(negedge clock);
        chk("ld_active_cleared", int'(ld_active), 0);
        tick();
        gm_req = 0;
        expect_ev("gm_rvalid_loaded", ev(0, 0, 1, 0, 0, 0, 0, 0, 2));
        tick();
        rn_req = 1; rn_x = 6'd39; rn_y = 5'd29;
        expect_ev("rn_rd_loaded", ev(0, 1, 0, 0, 0, 0, 1199, 0, 0));
        tick();
        rn_req = 0;
        expect_ev("rn_rvalid_loaded", ev(0, 0, 0, 1, 0, 0, 0, 0, 4));
        tick();

        // Reset right after a renderer grant
        rn_req = 1; rn_x = 6'd3; rn_y = 5'd0;
        expect_ev("rn_rd_prereset", ev(0, 1, 0, 0, 0, 0, 3, 0, 0));
        tick();
        rn_req = 0; reset = 1;
        @(negedge clock);
        chk("rn_rvalid_in_reset", int'(rn_rvalid), 0);
        tick();
        reset = 0;
        @(negedge clock);
        chk("rn_rvalid_after_reset", int'(rn_rvalid), 0);
        chk("ld_active_after_reset", int'(ld_active), 0);
        tick();

        // Partial starvation count must be cleared by reset
        gm_req = 1; gm_we = 1; gm_x = 6'd0; gm_y = 5'd1; gm_wdata = 3'd2;
        rn_req = 1; rn_x = 6'd4; rn_y = 5'd0;
        for (int i = 0; i < 5; i++) begin
            expect_ev("cont_pre_reset", ev(1, 0, 0, 0, 1, 0, 40, 2, 0));
            tick();
        end
        gm_req = 0; gm_we = 0; rn_req = 0; reset = 1;
        tick();
        reset = 0;
        tick();
        contention(4, 4);

        repeat (3) tick();
        chk("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
